// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shared memory port arbiter between fetch and data stages
// Data side has fixed priority; a starvation counter forces a fetch grant after STARVE_LIMIT denials.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_stall,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]         starve_q, starve_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  forced;

  always_comb begin
    forced = (starve_q == LIMIT) & if_req;
    if_gnt = forced | (if_req & ~d_req);
    d_gnt  = d_req & ~forced;
  end

  assign if_stall  = if_req & ~if_gnt;
  assign mem_addr  = d_gnt ? d_addr : if_addr;
  assign mem_we    = d_gnt & d_we;
  assign mem_be    = (d_gnt & d_we) ? d_be : '0;
  assign mem_wdata = d_wdata;

  always_comb begin
    starve_d = '0;
    if (if_req & ~if_gnt) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CW'(1);
    end
    if_rvalid_d = if_gnt;
    if_rdata_d  = if_gnt ? mem_rdata : if_rdata_q;
    d_rvalid_d  = d_gnt;
    // Stores acknowledge with zero data so a stale load value never leaks out.
    d_rdata_d   = d_gnt ? (d_we ? '0 : mem_rdata) : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - scoreboard bench for imem_port_arbiter with a reference model
// The reference tracks a consecutive-denial count and its own copy of memory bytes.
module tb_imem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_stall, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  imem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) env_mem[8'(mem_addr[7:0] + 8'(b))] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < 4; b++) mem_rdata[8*b +: 8] = env_mem[8'(mem_addr[7:0] + 8'(b))];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;
  resp_t ifq[$];
  resp_t dq[$];
  int    denied = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] d;
    for (int b = 0; b < 4; b++) d[8*b +: 8] = ref_mem[8'(a[7:0] + 8'(b))];
    return d;
  endfunction

  task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic dwe, input logic [31:0] daddr,
                      input logic [31:0] dwdata, input logic [3:0] dbe);
    logic        e_if, e_d;
    logic [31:0] e_addr;
    @(posedge clk);
    #1;
    reset = rst; if_req = ireq; if_addr = iaddr;
    d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata; d_be = dbe;
    e_if   = ireq && (denied >= LIMIT || !dreq);
    e_d    = dreq && !e_if;
    e_addr = e_d ? daddr : iaddr;
    @(negedge clk);
    check("if_gnt", 32'(if_gnt), 32'(e_if));
    check("d_gnt", 32'(d_gnt), 32'(e_d));
    check("if_stall", 32'(if_stall), 32'(ireq && !e_if));
    check("mem_addr", mem_addr, e_addr);
    check("mem_we", 32'(mem_we), 32'(e_d && dwe));
    check("mem_be", 32'(mem_be), (e_d && dwe) ? 32'(dbe) : 32'd0);
    check("mem_wdata", mem_wdata, dwdata);
    if (!rst) begin
      if (e_if) ifq.push_back('{cyc + 1, ref_read(iaddr)});
      if (e_d)  dq.push_back('{cyc + 1, dwe ? 32'd0 : ref_read(daddr)});
    end
    if (e_d && dwe) begin
      for (int b = 0; b < 4; b++)
        if (dbe[b]) ref_mem[8'(daddr[7:0] + 8'(b))] = dwdata[8*b +: 8];
    end
    if (rst || !ireq || e_if) denied = 0;
    else if (denied < LIMIT) denied++;
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  always @(negedge clk) begin
    resp_t r;
    if (if_rvalid) begin
      if (ifq.size() == 0) check("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
      else begin
        r = ifq.pop_front();
        check("if_rvalid_cycle", 32'(cyc), 32'(r.due));
        check("if_rdata", if_rdata, r.data);
      end
    end else if (ifq.size() > 0 && ifq[0].due <= cyc) begin
      check("if_rvalid_missing", 32'(if_rvalid), 32'd1);
      void'(ifq.pop_front());
    end
    if (d_rvalid) begin
      if (dq.size() == 0) check("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
      else begin
        r = dq.pop_front();
        check("d_rvalid_cycle", 32'(cyc), 32'(r.due));
        check("d_rdata", d_rdata, r.data);
      end
    end else if (dq.size() > 0 && dq[0].due <= cyc) begin
      check("d_rvalid_missing", 32'(d_rvalid), 32'd1);
      void'(dq.pop_front());
    end
  end

  logic [9:0] seq_if, seq_d;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      env_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = 8'(i + 1);
      env_mem[i] = 8'(i + 1);
    end

    repeat (2) step(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    idle(1'b0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    idle(1'b0);

    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(1'b0);
    check("fetch_word", if_rdata, 32'h04030201);

    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0011);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    idle(1'b0);
    check("load_low_half", 32'(d_rdata[15:0]), 32'h0000BEEF);

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'(4 * i), 1'b1, 1'b0, 32'(100 + i), 32'h0, 4'h0);
      seq_if[i] = if_gnt;
      seq_d[i]  = d_gnt;
    end
    check("contention_if_pattern", 32'(seq_if), 32'h210);
    check("contention_d_pattern", 32'(seq_d), 32'h1EF);
    idle(1'b0);

    repeat (3) step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    step(1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
      seq_if[i] = if_gnt;
    end
    check("starve_clear_pattern", 32'(seq_if[4:0]), 32'h10);
    idle(1'b0);

    step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(1'b0);
    check("reset_drop_if_rvalid", 32'(if_rvalid), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(9) < 7), $urandom,
           ($urandom_range(9) < 6), $urandom_range(1), $urandom, $urandom,
           4'($urandom));
    end
    repeat (3) idle(1'b0);
    check("if_queue_drained", 32'(ifq.size()), 32'd0);
    check("d_queue_drained", 32'(dq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
